sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2: SRAM cycle length in clocks; legal values 2..15.
REQ-002 SHALL have parameter FAIR_MAX, default 4: consecutive video grants allowed while the CPU waits (fairness only).
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports vid_req in 1, vid_addr in 21, vid_ack out 1, vid_data out 8: video read requester.
REQ-006 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in 21, cpu_wdata in 8, cpu_ack out 1, cpu_rdata out 8: CPU read/write requester.
REQ-007 SHALL have ports sram_addr out 21, sram_data_o out 8, sram_data_i in 8, sram_data_oe out 1, sram_we_n out 1: low-byte SRAM bus; tristate is resolved outside this block.

Function
REQ-008 SHALL implement the states IDLE, VID, CPU_RD, CPU_WR and DONE.
REQ-009 In IDLE, SHALL take VID if vid_req is high, else CPU_WR if cpu_req and cpu_we are high, else CPU_RD if cpu_req is high, else stay in IDLE.
REQ-010 SHALL register the winner's address, and for writes the winner's data, on the IDLE->access transition; these values SHALL be held stable for the whole access.
REQ-011 SHALL stay ACCESS_CYCLES clocks in each access state, counted by a 4-bit counter.
REQ-012 In CPU_WR, SHALL hold sram_data_oe high for all access clocks and sram_we_n low for all but the last access clock.
REQ-013 Outside CPU_WR, sram_data_oe SHALL be 0 and sram_we_n SHALL be 1.
REQ-014 For reads, SHALL capture sram_data_i into vid_data or cpu_rdata on the last access clock.
REQ-015 SHALL then enter DONE for one clock, asserting exactly one of vid_ack or cpu_ack as a one-clock pulse, then return to IDLE.
REQ-016 Latency: with req high in IDLE at cycle t, access SHALL occupy t+1..t+ACCESS_CYCLES, ack SHALL occur at t+ACCESS_CYCLES+1, and IDLE SHALL resume at t+ACCESS_CYCLES+2.
REQ-017 Requesters SHALL hold req, addr and wdata until ack; req may still be high in the cycle after ack to request a new access.
REQ-018 The arbiter SHALL ignore requests during access states and DONE.
REQ-019 vid_data and cpu_rdata SHALL hold their value until the next read for that requester.
REQ-020 On simultaneous vid_req and cpu_req in IDLE, video SHALL win, subject to REQ-025.
REQ-021 When idle, sram_addr SHALL hold its last value.

Reset
REQ-022 Reset asserted in any cycle, including mid-access, SHALL abort the access and force state IDLE, counter 0, sram_we_n 1, sram_data_oe 0, vid_ack 0 and cpu_ack 0.
REQ-023 Reset SHALL clear sram_addr, sram_data_o, vid_data, cpu_rdata and the fairness counter to 0.
REQ-024 An aborted access SHALL produce no ack.

Configuration
REQ-025 With macro SRAM_FAIRNESS_EN defined:
- a 3-bit counter SHALL count video grants made while cpu_req is high;
- when the count reaches FAIR_MAX, the CPU SHALL win the next contended IDLE decision;
- the count SHALL clear on any CPU grant, and on IDLE with cpu_req low.
REQ-026 Without SRAM_FAIRNESS_EN, priority SHALL be strict video-first and the fairness counter logic SHALL be absent.

Verification
REQ-027 Single CPU write, ACCESS_CYCLES=2, cpu_addr=0x01234, wdata=0xA5 -> sram_addr=0x01234, oe high 2 clocks, we_n low 1 clock, cpu_ack 3 clocks after req.
REQ-028 CPU read of 0x1FFFFF with the SRAM model returning 0x3C -> cpu_rdata=0x3C at the cpu_ack pulse; we_n stays 1 throughout.
REQ-029 vid_req and cpu_req both held high, fairness off -> only vid_ack pulses, every 4 clocks; cpu_ack never pulses.
REQ-030 Same stimulus with SRAM_FAIRNESS_EN, FAIR_MAX=4 -> four vid_ack pulses, then one cpu_ack, repeating.
REQ-031 Reset asserted on the second clock of a CPU write -> next clock we_n=1, oe=0, state IDLE; no cpu_ack.
REQ-032 ACCESS_CYCLES=15 video read -> vid_ack exactly 16 clocks after the request.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter (video reads, CPU read/write): ack ACCESS_CYCLES+1 clocks after a grant, requests ignored while busy.
// Strict video-first priority; define SRAM_FAIRNESS_EN to let a waiting CPU win after FAIR_MAX back-to-back video grants.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int FAIR_MAX      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data_o,
  input  logic [7:0]  sram_data_i,
  output logic        sram_data_oe,
  output logic        sram_we_n
);

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 || FAIR_MAX < 1 || FAIR_MAX > 7) begin : g_bad_param
    $error("sram_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, VID, CPU_RD, CPU_WR, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last;
  logic       in_access;
  logic       grant;
  logic       ack_cpu;
  logic       cpu_first;

  assign last      = (cnt == LAST);
  assign in_access = (state == VID) || (state == CPU_RD) || (state == CPU_WR);
  assign grant     = (state == IDLE) && (state_nxt != IDLE);

`ifdef SRAM_FAIRNESS_EN
  logic [2:0] fair_cnt;

  assign cpu_first = cpu_req && (fair_cnt >= 3'(FAIR_MAX));

  // Counts video wins over a waiting CPU; any CPU grant or an idle CPU resets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      fair_cnt <= 3'd0;
    end else if (state == IDLE) begin
      if (!cpu_req || state_nxt == CPU_RD || state_nxt == CPU_WR)
        fair_cnt <= 3'd0;
      else if (state_nxt == VID && fair_cnt != 3'd7)
        fair_cnt <= fair_cnt + 3'd1;
    end
  end
`else
  assign cpu_first = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (vid_req && !cpu_first)   state_nxt = VID;
        else if (cpu_req && cpu_we)  state_nxt = CPU_WR;
        else if (cpu_req)            state_nxt = CPU_RD;
      end
      VID, CPU_RD, CPU_WR: if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write strobe releases one clock before oe so data is held past the we_n rising edge.
  assign sram_data_oe = (state == CPU_WR);
  assign sram_we_n    = !((state == CPU_WR) && !last);
  assign vid_ack      = (state == DONE) && !ack_cpu;
  assign cpu_ack      = (state == DONE) && ack_cpu;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ack_cpu     <= 1'b0;
      sram_addr   <= 21'd0;
      sram_data_o <= 8'd0;
      vid_data    <= 8'd0;
      cpu_rdata   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (in_access && !last) ? cnt + 4'd1 : 4'd0;
      if (grant) begin
        sram_addr <= (state_nxt == VID) ? vid_addr : cpu_addr;
        ack_cpu   <= (state_nxt != VID);
        if (state_nxt == CPU_WR)
          sram_data_o <= cpu_wdata;
      end
      if (last && state == VID)
        vid_data <= sram_data_i;
      if (last && state == CPU_RD)
        cpu_rdata <= sram_data_i;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table, contention run, and a long-cycle instance.
module tb_sram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        vid_req, cpu_req, cpu_we;
  logic [20:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata, sram_data_i;
  logic        vid_ack, cpu_ack, sram_data_oe, sram_we_n;
  logic [7:0]  vid_data, cpu_rdata, sram_data_o;
  logic [20:0] sram_addr;

  logic        b_vid_req;
  logic [20:0] b_vid_addr;
  logic [7:0]  b_sram_data_i;
  logic        b_vid_ack, b_cpu_ack, b_oe, b_we_n;
  logic [7:0]  b_vid_data, b_cpu_rdata, b_data_o;
  logic [20:0] b_sram_addr;

  sram_arbiter #(.ACCESS_CYCLES(2), .FAIR_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .sram_data_oe(sram_data_oe), .sram_we_n(sram_we_n)
  );

  sram_arbiter #(.ACCESS_CYCLES(15), .FAIR_MAX(4)) dut_long (
    .clock(clock), .reset(reset),
    .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_ack(b_vid_ack), .vid_data(b_vid_data),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(21'd0), .cpu_wdata(8'd0),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .sram_addr(b_sram_addr), .sram_data_o(b_data_o), .sram_data_i(b_sram_data_i),
    .sram_data_oe(b_oe), .sram_we_n(b_we_n)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, vreq, creq, cwe;
    logic [20:0] vaddr, caddr;
    logic [7:0]  wdata, sdi;
    logic        chk;
    logic [48:0] exp;
  } vec_t;

  vec_t v [18];

  function automatic vec_t mkv(input logic rst, vreq, creq, cwe,
                               input logic [20:0] vaddr, caddr,
                               input logic [7:0] wdata, sdi,
                               input logic chk, vack, cack, oe, wen,
                               input logic [20:0] addr,
                               input logic [7:0] dout, vd, rd);
    vec_t r;
    r.rst = rst; r.vreq = vreq; r.creq = creq; r.cwe = cwe;
    r.vaddr = vaddr; r.caddr = caddr; r.wdata = wdata; r.sdi = sdi;
    r.chk = chk;
    r.exp = {vack, cack, oe, wen, addr, dout, vd, rd};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    logic exp_cpu;
    int   k;

    reset = 1'b1; vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = 0; cpu_addr = 0; cpu_wdata = 0; sram_data_i = 0;
    b_vid_req = 0; b_vid_addr = 0; b_sram_data_i = 0;

    //        rst vr cr we  vaddr       caddr        wdata  sdi    chk va ca oe wn addr        dout   vd     rd
    v[0]  = mkv(1, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 0, 0, 0, 0, 1, 21'h0,      8'h00, 8'h00, 8'h00);
    v[1]  = mkv(0, 0, 1, 1, 21'h0,      21'h01234,  8'hA5, 8'h00, 1, 0, 0, 0, 1, 21'h0,      8'h00, 8'h00, 8'h00);
    v[2]  = mkv(0, 0, 1, 1, 21'h0,      21'h01234,  8'hA5, 8'h00, 1, 0, 0, 1, 0, 21'h01234,  8'hA5, 8'h00, 8'h00);
    v[3]  = mkv(0, 0, 1, 1, 21'h0,      21'h01234,  8'hA5, 8'h00, 1, 0, 0, 1, 1, 21'h01234,  8'hA5, 8'h00, 8'h00);
    v[4]  = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 0, 1, 0, 1, 21'h01234,  8'hA5, 8'h00, 8'h00);
    v[5]  = mkv(0, 0, 1, 0, 21'h0,      21'h1FFFFF, 8'h00, 8'h00, 1, 0, 0, 0, 1, 21'h01234,  8'hA5, 8'h00, 8'h00);
    v[6]  = mkv(0, 0, 1, 0, 21'h0,      21'h1FFFFF, 8'h00, 8'h99, 1, 0, 0, 0, 1, 21'h1FFFFF, 8'hA5, 8'h00, 8'h00);
    v[7]  = mkv(0, 0, 1, 0, 21'h0,      21'h1FFFFF, 8'h00, 8'h3C, 1, 0, 0, 0, 1, 21'h1FFFFF, 8'hA5, 8'h00, 8'h00);
    v[8]  = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 0, 1, 0, 1, 21'h1FFFFF, 8'hA5, 8'h00, 8'h3C);
    v[9]  = mkv(0, 1, 0, 0, 21'h00ABC,  21'h0,      8'h00, 8'h3C, 1, 0, 0, 0, 1, 21'h1FFFFF, 8'hA5, 8'h00, 8'h3C);
    v[10] = mkv(0, 1, 0, 0, 21'h00ABC,  21'h0,      8'h00, 8'h11, 1, 0, 0, 0, 1, 21'h00ABC,  8'hA5, 8'h00, 8'h3C);
    v[11] = mkv(0, 1, 0, 0, 21'h00ABC,  21'h0,      8'h00, 8'h5A, 1, 0, 0, 0, 1, 21'h00ABC,  8'hA5, 8'h00, 8'h3C);
    v[12] = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 1, 0, 0, 1, 21'h00ABC,  8'hA5, 8'h5A, 8'h3C);
    v[13] = mkv(0, 0, 1, 1, 21'h0,      21'h00777,  8'h3F, 8'h00, 1, 0, 0, 0, 1, 21'h00ABC,  8'hA5, 8'h5A, 8'h3C);
    v[14] = mkv(1, 0, 1, 1, 21'h0,      21'h00777,  8'h3F, 8'h00, 1, 0, 0, 1, 0, 21'h00777,  8'h3F, 8'h5A, 8'h3C);
    v[15] = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 0, 0, 0, 1, 21'h0,      8'h00, 8'h00, 8'h00);
    v[16] = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 0, 0, 0, 1, 21'h0,      8'h00, 8'h00, 8'h00);
    v[17] = mkv(0, 0, 0, 0, 21'h0,      21'h0,      8'h00, 8'h00, 1, 0, 0, 0, 1, 21'h0,      8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      reset = v[i].rst; vid_req = v[i].vreq; cpu_req = v[i].creq; cpu_we = v[i].cwe;
      vid_addr = v[i].vaddr; cpu_addr = v[i].caddr; cpu_wdata = v[i].wdata;
      sram_data_i = v[i].sdi;
      #1;
      if (v[i].chk)
        check($sformatf("row%0d", i),
              64'({vid_ack, cpu_ack, sram_data_oe, sram_we_n, sram_addr, sram_data_o, vid_data, cpu_rdata}),
              64'(v[i].exp));
    end

    // Both requesters held high: grants every 4 clocks, ack in the 4th.
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      vid_req = 1; cpu_req = 1; cpu_we = 0;
      vid_addr = 21'h00100; cpu_addr = 21'h00200; sram_data_i = 8'h77;
      #1;
      k = i / 4;
`ifdef SRAM_FAIRNESS_EN
      exp_cpu = ((k % 5) == 4);
`else
      exp_cpu = 1'b0;
`endif
      if ((i % 4) == 3)
        check($sformatf("contend%0d", i), 64'({vid_ack, cpu_ack, sram_we_n}), 64'({!exp_cpu, exp_cpu, 1'b1}));
      else
        check($sformatf("contend%0d", i), 64'({vid_ack, cpu_ack, sram_we_n}), 64'({1'b0, 1'b0, 1'b1}));
    end
    @(negedge clock);
    vid_req = 0; cpu_req = 0;

    // Long access: ack exactly 16 clocks after the request, then back to idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      b_vid_req = (i < 16);
      b_vid_addr = 21'h0BEEF;
      b_sram_data_i = 8'hC3;
      #1;
      check($sformatf("long_ack%0d", i), 64'(b_vid_ack), 64'(i == 16));
      if (i == 16)
        check("long_data", 64'(b_vid_data), 64'(8'hC3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
